mmio_port_bank: RTL and testbench

MMIO_PORT_BANK -- requirements
Module: mmio_port_bank

---
 rtl/JZJCoreFTypes.sv | 23 ++
 rtl/mmio_input_sync.sv | 42 ++++
 rtl/mmio_port_bank.sv | 88 ++++++++
 tb/tb_mmio_port_bank.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/JZJCoreFTypes.sv
// Shared core types: write-enable encoding, byte-enable mask and MMIO limits.
// byte_mask expands a 4-bit byte enable into a 32-bit bit mask.
package JZJCoreFTypes;

   typedef enum logic {
      WRITE_DISABLE = 1'b0,
      WRITE_ENABLE  = 1'b1
   } WriteEnable_t;

   typedef logic [3:0] ByteEnable_t;

   localparam int unsigned MMIO_MAX_PORTS = 32;

   function automatic logic [31:0] byte_mask(input ByteEnable_t be);
      logic [31:0] m;
      m = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{be[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/mmio_input_sync.sv
// One MMIO input port: synchronizer chain, previous-value register and sticky
// per-bit change flags with write-1-to-clear.
module mmio_input_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pin_i,
   input  logic [31:0] clear_i,
   output logic [31:0] value_o,
   output logic [31:0] flags_o
);

   logic [SYNC_STAGES-1:0][31:0] sync_q;
   logic [31:0]                  prev_q;
   logic [31:0]                  flags_q;
   logic [31:0]                  flags_d;

   // Set term is OR-ed after the clear so a same-cycle set always wins.
   always_comb begin
      flags_d = (flags_q & ~clear_i) | (sync_q[SYNC_STAGES-1] ^ prev_q);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         prev_q  <= '0;
         flags_q <= '0;
      end else begin
         sync_q[0] <= pin_i;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q  <= sync_q[SYNC_STAGES-1];
         flags_q <= flags_d;
      end
   end

   assign value_o = sync_q[SYNC_STAGES-1];
   assign flags_o = flags_q;

endmodule

// File: rtl/mmio_port_bank.sv
// Bank of memory-mapped 32-bit ports: bank 0 reads synchronized inputs and
// writes registered outputs; bank 1 reads/clears the sticky change flags.
module mmio_port_bank
   import JZJCoreFTypes::*;
#(
   parameter int unsigned RAM_A_WIDTH = 12,
   parameter int unsigned NUM_PORTS   = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [RAM_A_WIDTH:0]           backendAddress,
   input  logic [31:0]                    rs2,
   input  WriteEnable_t                   mmioWriteEnable,
   input  ByteEnable_t                    byteEnable,
   output logic [31:0]                    mmioDataOut,
   input  logic [NUM_PORTS-1:0][31:0]     mmioInputs,
   output logic [NUM_PORTS-1:0][31:0]     mmioOutputs,
   output logic [NUM_PORTS-1:0]           outputStrobe,
   output logic                           irq
);

   localparam int unsigned P = $clog2(NUM_PORTS);

   logic [P-1:0]                  port_idx;
   logic                          bank;
   logic [31:0]                   wmask;
   logic                          bank0_wr;
   logic                          bank1_wr;
   logic [NUM_PORTS-1:0][31:0]    sync_val;
   logic [NUM_PORTS-1:0][31:0]    flags;
   logic [NUM_PORTS-1:0][31:0]    outputs_q;
   logic [NUM_PORTS-1:0][31:0]    outputs_d;
   logic [NUM_PORTS-1:0]          strobe_q;
   logic [NUM_PORTS-1:0]          strobe_d;
   logic                          irq_q;
   logic                          unused_addr_hi;

   assign port_idx       = backendAddress[P-1:0];
   assign bank           = backendAddress[P];
   assign unused_addr_hi = ^backendAddress[RAM_A_WIDTH:P+1];
   assign wmask          = byte_mask(byteEnable);
   assign bank0_wr       = (mmioWriteEnable == WRITE_ENABLE) && !bank && (byteEnable != '0);
   assign bank1_wr       = (mmioWriteEnable == WRITE_ENABLE) && bank;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      logic [31:0] clear;
      assign clear = (bank1_wr && (port_idx == P'(g))) ? (rs2 & wmask) : '0;

      mmio_input_sync #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clock   (clock),
         .reset   (reset),
         .pin_i   (mmioInputs[g]),
         .clear_i (clear),
         .value_o (sync_val[g]),
         .flags_o (flags[g])
      );
   end

   always_comb begin
      outputs_d = outputs_q;
      strobe_d  = '0;
      if (bank0_wr) begin
         outputs_d[port_idx] = (outputs_q[port_idx] & ~wmask) | (rs2 & wmask);
         strobe_d[port_idx]  = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outputs_q <= '0;
         strobe_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         outputs_q <= outputs_d;
         strobe_q  <= strobe_d;
         irq_q     <= |flags;
      end
   end

   assign mmioDataOut  = bank ? flags[port_idx] : sync_val[port_idx];
   assign mmioOutputs  = outputs_q;
   assign outputStrobe = strobe_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed self-checking bench for mmio_port_bank with default parameters.
module tb_mmio_port_bank;
   import JZJCoreFTypes::*;

   logic              clock;
   logic              reset;
   logic [12:0]       addr;
   logic [31:0]       rs2;
   WriteEnable_t      we;
   ByteEnable_t       be;
   logic [31:0]       dout;
   logic [7:0][31:0]  inputs;
   logic [7:0][31:0]  outputs;
   logic [7:0]        strobe;
   logic              irq;

   int checks = 0;
   int errors = 0;

   mmio_port_bank #(
      .RAM_A_WIDTH (12),
      .NUM_PORTS   (8),
      .SYNC_STAGES (2)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .backendAddress  (addr),
      .rs2             (rs2),
      .mmioWriteEnable (we),
      .byteEnable      (be),
      .mmioDataOut     (dout),
      .mmioInputs      (inputs),
      .mmioOutputs     (outputs),
      .outputStrobe    (strobe),
      .irq             (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // High address bits carry junk to show they are ignored.
   task automatic set_addr(input logic b, input logic [2:0] idx);
      addr = {9'h15A, b, idx};
   endtask

   task automatic wr(input logic b, input logic [2:0] idx, input logic [31:0] d, input ByteEnable_t e);
      set_addr(b, idx);
      rs2 = d;
      be  = e;
      we  = WRITE_ENABLE;
   endtask

   task automatic idle();
      we = WRITE_DISABLE;
      be = '0;
   endtask

   initial begin
      reset  = 1'b1;
      we     = WRITE_DISABLE;
      be     = '0;
      rs2    = '0;
      addr   = '0;
      inputs = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) chk($sformatf("rst_out%0d", i), outputs[i], 32'h0);
      chk("rst_strobe", {24'h0, strobe}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      set_addr(1'b0, 3'd0); #1;
      chk("rst_rd_b0", dout, 32'h0);
      set_addr(1'b1, 3'd7); #1;
      chk("rst_rd_b1", dout, 32'h0);

      wr(1'b0, 3'd3, 32'h11223344, 4'hF);
      tick();
      chk("wr_full", outputs[3], 32'h11223344);
      chk("wr_full_stb", {24'h0, strobe}, 32'h08);
      wr(1'b0, 3'd3, 32'hAABBCCDD, 4'h5);
      tick();
      chk("wr_be0101", outputs[3], 32'h11BB33DD);
      chk("wr_b2b_stb", {24'h0, strobe}, 32'h08);
      wr(1'b0, 3'd3, 32'hFFFFFFFF, 4'h0);
      tick();
      chk("wr_be0_stb", {24'h0, strobe}, 32'h0);
      chk("wr_be0_val", outputs[3], 32'h11BB33DD);
      chk("wr_other2", outputs[2], 32'h0);
      chk("wr_other4", outputs[4], 32'h0);
      wr(1'b0, 3'd3, 32'h11BB33DD, 4'hF);
      tick();
      chk("wr_same_stb", {24'h0, strobe}, 32'h08);
      idle();
      tick();
      chk("wr_idle_stb", {24'h0, strobe}, 32'h0);

      inputs[5] = 32'h0000F00F;
      set_addr(1'b0, 3'd5);
      tick();
      chk("sync_lag1", dout, 32'h0);
      tick();
      chk("sync_lag2", dout, 32'h0000F00F);
      set_addr(1'b1, 3'd5); #1;
      chk("flag_pre", dout, 32'h0);
      tick();
      chk("flag_set", dout, 32'h0000F00F);
      chk("irq_pre", {31'h0, irq}, 32'h0);
      tick();
      chk("irq_set", {31'h0, irq}, 32'h1);

      wr(1'b1, 3'd5, 32'h0000000F, 4'hF);
      tick();
      chk("w1c_low", dout, 32'h0000F000);
      chk("w1c_irq_hold", {31'h0, irq}, 32'h1);
      wr(1'b1, 3'd5, 32'h0000F000, 4'h1);
      tick();
      chk("w1c_be_masked", dout, 32'h0000F000);
      wr(1'b1, 3'd5, 32'h0000F000, 4'hF);
      tick();
      chk("w1c_all", dout, 32'h0);
      chk("w1c_out5", outputs[5], 32'h0);
      idle();
      tick();
      chk("irq_clear", {31'h0, irq}, 32'h0);

      inputs[5] = 32'h0000F00E;
      repeat (3) tick();
      chk("toggle_flag", dout, 32'h1);
      inputs[5] = 32'h0000F00F;
      tick();
      tick();
      wr(1'b1, 3'd5, 32'h00000001, 4'h1);
      tick();
      chk("set_wins", dout, 32'h1);
      tick();
      chk("w1c_bit0", dout, 32'h0);
      idle();

      wr(1'b0, 3'd0, 32'h12345678, 4'hF);
      tick();
      chk("pre_rst_out0", outputs[0], 32'h12345678);
      chk("pre_rst_stb", {24'h0, strobe}, 32'h01);
      wr(1'b0, 3'd0, 32'hFFFFFFFF, 4'hF);
      #2;
      reset = 1'b1;
      #1;
      chk("async_out0", outputs[0], 32'h0);
      chk("async_stb", {24'h0, strobe}, 32'h0);
      chk("async_irq", {31'h0, irq}, 32'h0);
      @(posedge clock);
      #1;
      idle();
      reset = 1'b0;
      tick();
      chk("post_rst_stb", {24'h0, strobe}, 32'h0);
      chk("post_rst_out0", outputs[0], 32'h0);
      set_addr(1'b1, 3'd5); #1;
      chk("hold_flag1", dout, 32'h0);
      tick();
      chk("hold_flag2", dout, 32'h0);
      tick();
      chk("hold_flag3", dout, 32'h0000F00F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
